pmu_ahb_master: RTL and testbench

- Single-outstanding AHB-Lite master that drives the PMU's AHB slave port (hsel/haddr/htrans/hwrite/hwdata in; hrdata/hready/hresp out).
- Converts a simple valid/ready register-access request from a local controller (debug bridge or scrubber FSM) into one NONSEQ single transfer and returns read data and status.
- Sits directly upstream of the PMU and replaces ad-hoc bus driving.

---
 rtl/pmu_ahb_pkg.sv | 27 ++
 rtl/pmu_ahb_wdog.sv | 50 +++++
 rtl/pmu_ahb_master.sv | 220 ++++++++++++++++++++++
 tb/tb_pmu_ahb_master.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmu_ahb_pkg.sv
// -----------------------------------------------------------------------------
// pmu_ahb_pkg
// Shared AHB-Lite encodings and the FSM state type for the PMU AHB master.
//   HTRANS_IDLE / HTRANS_NONSEQ : htrans encodings used by a single-transfer master
//   HRESP_OKAY  / HRESP_ERROR   : hresp encodings returned by the PMU slave
//   HSIZE_WORD / HBURST_SINGLE  : fixed transfer attributes
//   ahbm_state_t                : IDLE, ADDR, DATA, RESP
// -----------------------------------------------------------------------------
package pmu_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10,
        RESP = 2'b11
    } ahbm_state_t;

endpackage

// File: rtl/pmu_ahb_wdog.sv
// -----------------------------------------------------------------------------
// pmu_ahb_wdog
// Wait-state watchdog for the PMU AHB master. Only built when
// PMU_AHB_MASTER_TIMEOUT_EN is defined.
// Counts consecutive stalled cycles (enable_i high); any non-stalled cycle
// restarts the count. expired_o is asserted combinationally during the
// TIMEOUT_CYCLES-th consecutive stalled cycle so the master can abort on
// the very edge where the count would reach TIMEOUT_CYCLES.
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset
//   clear_i   restart counting (new transfer entering the address phase)
//   enable_i  current cycle is a stalled bus cycle
//   expired_o stall limit reached this cycle
// -----------------------------------------------------------------------------
`ifdef PMU_AHB_MASTER_TIMEOUT_EN
module pmu_ahb_wdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_STALL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_r;

    assign expired_o = enable_i & (count_r == LAST_STALL);

    // Consecutive stall counter, saturating once the limit is hit.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable_i) begin
            if (!expired_o) begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                count_r <= count_r;
            end
        end else begin
            count_r <= {CNT_W{1'b0}};
        end
    end

endmodule
`endif

// File: rtl/pmu_ahb_master.sv
// -----------------------------------------------------------------------------
// pmu_ahb_master
// Single-outstanding AHB-Lite master in front of the PMU slave port. A
// valid/ready register request becomes one NONSEQ single word transfer; the
// result comes back as a one-cycle rsp_valid_o pulse with data and status.
// Requests outside the PMU window complete with an error and no bus activity.
//
// Optional feature (macro PMU_AHB_MASTER_TIMEOUT_EN): a wait-state watchdog
// aborts a transfer after TIMEOUT_CYCLES consecutive hready_i=0 cycles and
// pulses timeout_o together with the error response.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i / req_ready_o    request handshake
//   req_write_i, req_addr_i,
//   req_wdata_i                  request direction, byte address, write data
//   rsp_valid_o                  one-cycle completion pulse
//   rsp_rdata_o, rsp_err_o       read data / error, held until next response
//   hsel_o, haddr_o, htrans_o,
//   hwrite_o, hsize_o, hburst_o,
//   hwdata_o                     AHB-Lite master outputs
//   hrdata_i, hready_i, hresp_i  AHB-Lite slave responses
//   timeout_o                    watchdog abort pulse (macro only)
// -----------------------------------------------------------------------------
module pmu_ahb_master
    import pmu_ahb_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] HADDR_BASE     = 32'h8010_0000,
    parameter logic [ADDR_WIDTH-1:0] HMASK          = 32'h0000_0fff,
    parameter int                    TIMEOUT_CYCLES = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  hsel_o,
    output logic [ADDR_WIDTH-1:0] haddr_o,
    output logic [1:0]            htrans_o,
    output logic                  hwrite_o,
    output logic [2:0]            hsize_o,
    output logic [2:0]            hburst_o,
    output logic [DATA_WIDTH-1:0] hwdata_o,
    input  logic [DATA_WIDTH-1:0] hrdata_i,
    input  logic                  hready_i,
    input  logic [1:0]            hresp_i
`ifdef PMU_AHB_MASTER_TIMEOUT_EN
    ,
    output logic                  timeout_o
`endif
);

    ahbm_state_t           state_r;
    ahbm_state_t           state_next_s;

    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic                  write_r;
    logic                  err_r;
    logic                  err_next_s;
    logic                  data_err_s;

    logic                  hsel_r;
    logic [1:0]            htrans_r;
    logic                  rsp_valid_r;
    logic                  rsp_err_r;
    logic                  rsp_err_next_s;
    logic [DATA_WIDTH-1:0] rsp_rdata_r;
    logic [DATA_WIDTH-1:0] rsp_rdata_next_s;

    logic                  handshake_s;
    logic                  hit_s;
    logic                  timeout_s;

    // Ready is withheld while reset is asserted so nothing is accepted then.
    assign req_ready_o = (state_r == IDLE) & ~rst_i;
    assign handshake_s = req_valid_i & req_ready_o;
    assign hit_s       = ((req_addr_i ^ HADDR_BASE) & ~HMASK) == {ADDR_WIDTH{1'b0}};

    assign hsel_o      = hsel_r;
    assign htrans_o    = htrans_r;
    assign haddr_o     = addr_r;
    assign hwrite_o    = write_r;
    assign hwdata_o    = wdata_r;
    assign hsize_o     = HSIZE_WORD;
    assign hburst_o    = HBURST_SINGLE;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_err_o   = rsp_err_r;
    assign rsp_rdata_o = rsp_rdata_r;

`ifdef PMU_AHB_MASTER_TIMEOUT_EN
    logic wdog_clear_s;
    logic wdog_enable_s;
    logic timeout_r;

    assign wdog_clear_s  = handshake_s & hit_s;
    assign wdog_enable_s = ((state_r == ADDR) | (state_r == DATA)) & ~hready_i;
    assign timeout_o     = timeout_r;

    pmu_ahb_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (wdog_clear_s),
        .enable_i  (wdog_enable_s),
        .expired_o (timeout_s)
    );

    // Abort pulse lines up with the error response it causes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= timeout_s;
        end
    end
`else
    logic [31:0] unused_timeout_cfg_s;

    assign timeout_s            = 1'b0;
    assign unused_timeout_cfg_s = 32'(TIMEOUT_CYCLES);
`endif

    // Next-state, sticky bus error and next response contents.
    always_comb begin
        state_next_s     = state_r;
        err_next_s       = err_r;
        rsp_err_next_s   = rsp_err_r;
        rsp_rdata_next_s = rsp_rdata_r;
        // ERROR may arrive in the first (hready=0) cycle of a two-cycle response.
        data_err_s       = err_r | (hresp_i == HRESP_ERROR);

        case (state_r)
            IDLE: begin
                if (handshake_s) begin
                    err_next_s = 1'b0;
                    if (hit_s) begin
                        state_next_s = ADDR;
                    end else begin
                        state_next_s     = RESP;
                        rsp_err_next_s   = 1'b1;
                        rsp_rdata_next_s = {DATA_WIDTH{1'b0}};
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ADDR: begin
                if (timeout_s) begin
                    state_next_s     = RESP;
                    rsp_err_next_s   = 1'b1;
                    rsp_rdata_next_s = {DATA_WIDTH{1'b0}};
                end else if (hready_i) begin
                    state_next_s = DATA;
                end else begin
                    state_next_s = ADDR;
                end
            end
            DATA: begin
                err_next_s = data_err_s;
                if (timeout_s) begin
                    state_next_s     = RESP;
                    rsp_err_next_s   = 1'b1;
                    rsp_rdata_next_s = {DATA_WIDTH{1'b0}};
                end else if (hready_i) begin
                    state_next_s     = RESP;
                    rsp_err_next_s   = data_err_s;
                    rsp_rdata_next_s = (data_err_s | write_r) ? {DATA_WIDTH{1'b0}} : hrdata_i;
                end else begin
                    state_next_s = DATA;
                end
            end
            RESP: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, request capture and registered bus/response outputs. Bus outputs
    // are derived from the next state so they change on the same edge as it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            wdata_r     <= {DATA_WIDTH{1'b0}};
            write_r     <= 1'b0;
            err_r       <= 1'b0;
            hsel_r      <= 1'b0;
            htrans_r    <= HTRANS_IDLE;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r <= state_next_s;
            err_r   <= err_next_s;
            if (handshake_s) begin
                addr_r  <= req_addr_i;
                wdata_r <= req_wdata_i;
                write_r <= req_write_i;
            end
            hsel_r      <= (state_next_s == ADDR);
            htrans_r    <= (state_next_s == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
            rsp_valid_r <= (state_next_s == RESP);
            rsp_err_r   <= rsp_err_next_s;
            rsp_rdata_r <= rsp_rdata_next_s;
        end
    end

endmodule

// File: tb/tb_pmu_ahb_master.sv
// -----------------------------------------------------------------------------
// tb_pmu_ahb_master
// Cycle-by-cycle vector table for the PMU AHB master plus hand-written
// sequences for reset during a stalled data phase and (with
// PMU_AHB_MASTER_TIMEOUT_EN) the wait-state watchdog.
// -----------------------------------------------------------------------------
module tb_pmu_ahb_master;
    import pmu_ahb_pkg::*;

    logic        clk_i;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        hsel_o;
    logic [31:0] haddr_o;
    logic [1:0]  htrans_o;
    logic        hwrite_o;
    logic [2:0]  hsize_o;
    logic [2:0]  hburst_o;
    logic [31:0] hwdata_o;
    logic [31:0] hrdata_i;
    logic        hready_i;
    logic [1:0]  hresp_i;
`ifdef PMU_AHB_MASTER_TIMEOUT_EN
    logic        timeout_o;
`endif

    pmu_ahb_master #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .hsel_o      (hsel_o),
        .haddr_o     (haddr_o),
        .htrans_o    (htrans_o),
        .hwrite_o    (hwrite_o),
        .hsize_o     (hsize_o),
        .hburst_o    (hburst_o),
        .hwdata_o    (hwdata_o),
        .hrdata_i    (hrdata_i),
        .hready_i    (hready_i),
        .hresp_i     (hresp_i)
`ifdef PMU_AHB_MASTER_TIMEOUT_EN
        ,
        .timeout_o   (timeout_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        rst;
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        hready;
        logic [1:0]  hresp;
        logic [31:0] hrdata;
    } ins_t;

    typedef struct packed {
        logic        ready;
        logic        hsel;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [31:0] haddr;
        logic [31:0] hwdata;
        logic        rvalid;
        logic        rerr;
        logic [31:0] rdata;
    } outs_t;

    typedef struct packed {
        ins_t  i;
        outs_t o;
    } vec_t;

    localparam int NV = 29;
    localparam logic [1:0]  OK = HRESP_OKAY;
    localparam logic [1:0]  ER = HRESP_ERROR;
    localparam logic [1:0]  NS = HTRANS_NONSEQ;
    localparam logic [1:0]  ID = HTRANS_IDLE;
    localparam logic [31:0] A1 = 32'h8010_00ac;
    localparam logic [31:0] D1 = 32'hcafe_cafe;
    localparam logic [31:0] A2 = 32'h8010_00b0;
    localparam logic [31:0] A3 = 32'h8010_00b4;
    localparam logic [31:0] D3 = 32'h5a5a_5a5a;
    localparam logic [31:0] A4 = 32'h8020_0000;
    localparam logic [31:0] A5 = 32'h8010_0ffc;
    localparam logic [31:0] A6 = 32'h8010_0000;
    localparam logic [31:0] A7 = 32'h8010_00b8;
    localparam logic [31:0] D7 = 32'h1357_2468;
    localparam logic [31:0] Z  = 32'h0000_0000;

    vec_t vecs [NV];
    int   errors = 0;
    int   checks = 0;

    function automatic ins_t mk_in(logic rst, logic valid, logic write, logic [31:0] addr,
                                   logic [31:0] wdata, logic hready, logic [1:0] hresp,
                                   logic [31:0] hrdata);
        ins_t r;
        r = '{rst, valid, write, addr, wdata, hready, hresp, hrdata};
        return r;
    endfunction

    function automatic outs_t mk_out(logic ready, logic hsel, logic [1:0] htrans, logic hwrite,
                                     logic [31:0] haddr, logic [31:0] hwdata, logic rvalid,
                                     logic rerr, logic [31:0] rdata);
        outs_t r;
        r = '{ready, hsel, htrans, hwrite, haddr, hwdata, rvalid, rerr, rdata};
        return r;
    endfunction

    function automatic outs_t sample_outs();
        return mk_out(req_ready_o, hsel_o, htrans_o, hwrite_o, haddr_o, hwdata_o,
                      rsp_valid_o, rsp_err_o, rsp_rdata_o);
    endfunction

    task automatic drive(input ins_t v);
        rst_i       = v.rst;
        req_valid_i = v.valid;
        req_write_i = v.write;
        req_addr_i  = v.addr;
        req_wdata_i = v.wdata;
        hready_i    = v.hready;
        hresp_i     = v.hresp;
        hrdata_i    = v.hrdata;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_outs(input string name, input outs_t exp);
        outs_t got;
        got = sample_outs();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic set_row(input int k, input ins_t i, input outs_t o);
        vecs[k].i = i;
        vecs[k].o = o;
    endtask

    initial begin
        int   lat;
        int   pulses;
        logic cap_err;
        logic [31:0] cap_rdata;
        ins_t idle_in;

        idle_in = mk_in(1'b0, 1'b0, 1'b0, Z, Z, 1'b1, OK, Z);

        // reset
        set_row(0,  mk_in(1'b1, 1'b0, 1'b0, Z, Z, 1'b1, OK, Z),            mk_out(1'b0, 1'b0, ID, 1'b0, Z,  Z,  1'b0, 1'b0, Z));
        // write A1 = D1, zero wait states
        set_row(1,  mk_in(1'b0, 1'b1, 1'b1, A1, D1, 1'b1, OK, Z),          mk_out(1'b1, 1'b0, ID, 1'b0, Z,  Z,  1'b0, 1'b0, Z));
        set_row(2,  idle_in,                                               mk_out(1'b0, 1'b1, NS, 1'b1, A1, D1, 1'b0, 1'b0, Z));
        set_row(3,  idle_in,                                               mk_out(1'b0, 1'b0, ID, 1'b1, A1, D1, 1'b0, 1'b0, Z));
        set_row(4,  idle_in,                                               mk_out(1'b0, 1'b0, ID, 1'b1, A1, D1, 1'b1, 1'b0, Z));
        // read A2, three data-phase wait states
        set_row(5,  mk_in(1'b0, 1'b1, 1'b0, A2, Z, 1'b1, OK, Z),           mk_out(1'b1, 1'b0, ID, 1'b1, A1, D1, 1'b0, 1'b0, Z));
        set_row(6,  idle_in,                                               mk_out(1'b0, 1'b1, NS, 1'b0, A2, Z,  1'b0, 1'b0, Z));
        set_row(7,  mk_in(1'b0, 1'b0, 1'b0, Z, Z, 1'b0, OK, 32'hdead_beef), mk_out(1'b0, 1'b0, ID, 1'b0, A2, Z, 1'b0, 1'b0, Z));
        set_row(8,  mk_in(1'b0, 1'b0, 1'b0, Z, Z, 1'b0, OK, 32'hdead_beef), mk_out(1'b0, 1'b0, ID, 1'b0, A2, Z, 1'b0, 1'b0, Z));
        set_row(9,  mk_in(1'b0, 1'b0, 1'b0, Z, Z, 1'b0, OK, 32'hdead_beef), mk_out(1'b0, 1'b0, ID, 1'b0, A2, Z, 1'b0, 1'b0, Z));
        set_row(10, mk_in(1'b0, 1'b0, 1'b0, Z, Z, 1'b1, OK, 32'h1234_5678), mk_out(1'b0, 1'b0, ID, 1'b0, A2, Z, 1'b0, 1'b0, Z));
        set_row(11, idle_in,                                               mk_out(1'b0, 1'b0, ID, 1'b0, A2, Z,  1'b1, 1'b0, 32'h1234_5678));
        // write A3 with two-cycle ERROR response
        set_row(12, mk_in(1'b0, 1'b1, 1'b1, A3, D3, 1'b1, OK, Z),          mk_out(1'b1, 1'b0, ID, 1'b0, A2, Z,  1'b0, 1'b0, 32'h1234_5678));
        set_row(13, idle_in,                                               mk_out(1'b0, 1'b1, NS, 1'b1, A3, D3, 1'b0, 1'b0, 32'h1234_5678));
        set_row(14, mk_in(1'b0, 1'b0, 1'b0, Z, Z, 1'b0, ER, Z),            mk_out(1'b0, 1'b0, ID, 1'b1, A3, D3, 1'b0, 1'b0, 32'h1234_5678));
        set_row(15, mk_in(1'b0, 1'b0, 1'b0, Z, Z, 1'b1, ER, 32'hffff_ffff), mk_out(1'b0, 1'b0, ID, 1'b1, A3, D3, 1'b0, 1'b0, 32'h1234_5678));
        set_row(16, idle_in,                                               mk_out(1'b0, 1'b0, ID, 1'b1, A3, D3, 1'b1, 1'b1, Z));
        // read outside the window
        set_row(17, mk_in(1'b0, 1'b1, 1'b0, A4, Z, 1'b1, OK, Z),           mk_out(1'b1, 1'b0, ID, 1'b1, A3, D3, 1'b0, 1'b1, Z));
        set_row(18, idle_in,                                               mk_out(1'b0, 1'b0, ID, 1'b0, A4, Z,  1'b1, 1'b1, Z));
        // read at top of window, ERROR together with hready in the only data cycle
        set_row(19, mk_in(1'b0, 1'b1, 1'b0, A5, Z, 1'b1, OK, Z),           mk_out(1'b1, 1'b0, ID, 1'b0, A4, Z,  1'b0, 1'b1, Z));
        set_row(20, idle_in,                                               mk_out(1'b0, 1'b1, NS, 1'b0, A5, Z,  1'b0, 1'b1, Z));
        set_row(21, mk_in(1'b0, 1'b0, 1'b0, Z, Z, 1'b1, ER, 32'h1111_1111), mk_out(1'b0, 1'b0, ID, 1'b0, A5, Z, 1'b0, 1'b1, Z));
        set_row(22, idle_in,                                               mk_out(1'b0, 1'b0, ID, 1'b0, A5, Z,  1'b1, 1'b1, Z));
        // read at window base, wait state in address phase, stray request ignored
        set_row(23, mk_in(1'b0, 1'b1, 1'b0, A6, Z, 1'b1, OK, Z),           mk_out(1'b1, 1'b0, ID, 1'b0, A5, Z,  1'b0, 1'b1, Z));
        set_row(24, mk_in(1'b0, 1'b1, 1'b1, A1, 32'hffff_ffff, 1'b0, OK, Z), mk_out(1'b0, 1'b1, NS, 1'b0, A6, Z, 1'b0, 1'b1, Z));
        set_row(25, idle_in,                                               mk_out(1'b0, 1'b1, NS, 1'b0, A6, Z,  1'b0, 1'b1, Z));
        set_row(26, mk_in(1'b0, 1'b0, 1'b0, Z, Z, 1'b1, OK, 32'h0bad_f00d), mk_out(1'b0, 1'b0, ID, 1'b0, A6, Z, 1'b0, 1'b1, Z));
        set_row(27, idle_in,                                               mk_out(1'b0, 1'b0, ID, 1'b0, A6, Z,  1'b1, 1'b0, 32'h0bad_f00d));
        set_row(28, idle_in,                                               mk_out(1'b1, 1'b0, ID, 1'b0, A6, Z,  1'b0, 1'b0, 32'h0bad_f00d));

        drive(mk_in(1'b1, 1'b0, 1'b0, Z, Z, 1'b1, OK, Z));
        tick();

        for (int k = 0; k < NV; k++) begin
            drive(vecs[k].i);
            #4;
            chk_outs($sformatf("vec%0d", k), vecs[k].o);
            if (k == 0) begin
                chk_val("hsize_hburst", {26'd0, hsize_o, hburst_o}, {26'd0, HSIZE_WORD, 3'b000});
            end
            tick();
        end

        // reset during a stalled data phase
        drive(mk_in(1'b0, 1'b1, 1'b0, A2, Z, 1'b1, OK, Z));
        tick();
        drive(idle_in);
        tick();
        drive(mk_in(1'b0, 1'b0, 1'b0, Z, Z, 1'b0, OK, 32'h7777_7777));
        tick();
        drive(mk_in(1'b1, 1'b0, 1'b0, Z, Z, 1'b0, OK, 32'h7777_7777));
        tick();
        drive(idle_in);
        #4;
        chk_outs("rst_mid_outs", mk_out(1'b1, 1'b0, ID, 1'b0, Z, Z, 1'b0, 1'b0, Z));
        for (int n = 0; n < 3; n++) begin
            tick();
            #4;
            chk_val($sformatf("rst_mid_no_rsp%0d", n), {31'd0, rsp_valid_o}, 32'd0);
        end
        tick();
        drive(mk_in(1'b0, 1'b1, 1'b1, A7, D7, 1'b1, OK, Z));
        tick();
        lat = -1;
        pulses = 0;
        cap_err = 1'b1;
        cap_rdata = 32'hffff_ffff;
        for (int n = 0; n < 10; n++) begin
            drive(idle_in);
            #4;
            if (n == 1) begin
                chk_val("post_rst_hwdata", hwdata_o, D7);
            end
            if (rsp_valid_o) begin
                pulses++;
                if (lat < 0) begin
                    lat = n;
                    cap_err = rsp_err_o;
                    cap_rdata = rsp_rdata_o;
                end
            end
            tick();
        end
        chk_val("post_rst_latency", lat, 32'd2);
        chk_val("post_rst_pulses", pulses, 32'd1);
        chk_val("post_rst_err", {31'd0, cap_err}, 32'd0);
        chk_val("post_rst_rdata", cap_rdata, Z);

`ifdef PMU_AHB_MASTER_TIMEOUT_EN
        // watchdog abort after 8 stalled cycles, then a normal read
        drive(mk_in(1'b0, 1'b1, 1'b0, A2, Z, 1'b0, OK, Z));
        tick();
        lat = -1;
        pulses = 0;
        cap_err = 1'b0;
        cap_rdata = Z;
        for (int n = 0; n < 20; n++) begin
            drive(mk_in(1'b0, 1'b0, 1'b0, Z, Z, 1'b0, OK, Z));
            #4;
            if (timeout_o) begin
                pulses++;
                if (lat < 0) begin
                    lat = n;
                    cap_err = rsp_err_o & rsp_valid_o;
                end
            end
            tick();
        end
        chk_val("to_latency", lat, 32'd8);
        chk_val("to_pulses", pulses, 32'd1);
        chk_val("to_rsp_err", {31'd0, cap_err}, 32'd1);

        drive(mk_in(1'b0, 1'b1, 1'b0, A3, Z, 1'b1, OK, 32'h2468_ace0));
        tick();
        lat = -1;
        pulses = 0;
        for (int n = 0; n < 10; n++) begin
            drive(mk_in(1'b0, 1'b0, 1'b0, Z, Z, 1'b1, OK, 32'h2468_ace0));
            #4;
            if (rsp_valid_o) begin
                pulses++;
                if (lat < 0) begin
                    lat = n;
                    cap_err = rsp_err_o;
                    cap_rdata = rsp_rdata_o;
                end
            end
            tick();
        end
        chk_val("after_to_latency", lat, 32'd2);
        chk_val("after_to_err", {31'd0, cap_err}, 32'd0);
        chk_val("after_to_rdata", cap_rdata, 32'h2468_ace0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
